// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - command codes, one-hot state encoding and command decode for spi_cmd_seq
package spi_cmd_pkg;

  localparam int unsigned CMD_NOP  = 0;
  localparam int unsigned CMD_FIFO = 1;
  localparam int unsigned CMD_RD   = 2;
  localparam int unsigned CMD_WR   = 3;

  localparam int IDLE_IDX = 0;
  localparam int RD_IDX   = 1;
  localparam int WR_IDX   = 2;
  localparam int FIFO_IDX = 3;

  typedef enum logic [3:0] {
    IDLE      = 4'(1 << IDLE_IDX),
    RD        = 4'(1 << RD_IDX),
    WR        = 4'(1 << WR_IDX),
    FIFO_SEND = 4'(1 << FIFO_IDX)
  } state_e;

  typedef enum logic [2:0] {
    K_NOP,
    K_FIFO,
    K_RD,
    K_WR,
    K_ILLEGAL
  } cmd_kind_e;

  function automatic cmd_kind_e decode_cmd(input logic [31:0] code);
    cmd_kind_e k;
    case (code)
      CMD_NOP:  k = K_NOP;
      CMD_FIFO: k = K_FIFO;
      CMD_RD:   k = K_RD;
      CMD_WR:   k = K_WR;
      default:  k = K_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/spi_cmd_seq_wdog.sv
// rtl/spi_cmd_seq_wdog.sv - spi_wdog: cycle watchdog, expire flags the cycle whose increment reaches TIMEOUT
module spi_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // expire is independent of clr so the caller can derive clr from its next state without a loop
  assign expire = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/spi_cmd_seq.sv
// rtl/spi_cmd_seq.sv - SPI slave command sequencer: RD/WR strobes, channelled FIFO packets, abort and watchdog
module spi_cmd_seq
  import spi_cmd_pkg::*;
#(
  parameter int CMD_W   = 4,
  parameter int CNT_W   = 8,
  parameter int N_CH    = 4,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [CNT_W-1:0] pk_sz,
  input  logic             done,
  input  logic             abort,
  output logic             rd_select,
  output logic             wr_select,
  output logic [N_CH-1:0]  fifo_select,
  output logic             busy,
  output logic [CNT_W-1:0] words_left,
  output logic             cmd_err,
  output logic             timeout_err
);

  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

  state_e           state, next_state;
  logic [CH_W-1:0]  ch_q, ch_next;
  logic [CNT_W-1:0] words_next;
  logic             err_next, tmo_next;
  logic             wd_clr, wd_en, wd_expire;
  cmd_kind_e        kind;

  assign kind = decode_cmd(32'(cmd));

  spi_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  assign wd_en  = (state != IDLE);
  assign wd_clr = done || (next_state != state);

  always_comb begin
    next_state = state;
    words_next = words_left;
    ch_next    = ch_q;
    err_next   = 1'b0;
    tmo_next   = timeout_err;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (kind)
            K_RD: begin
              next_state = RD;
              tmo_next   = 1'b0;
            end
            K_WR: begin
              next_state = WR;
              tmo_next   = 1'b0;
            end
            K_FIFO: begin
              if ({1'b0, ch_sel} >= N_CH_L) begin
                err_next = 1'b1;
              end else if (pk_sz != '0) begin
                next_state = FIFO_SEND;
                ch_next    = ch_sel;
                words_next = pk_sz;
                tmo_next   = 1'b0;
              end
            end
            K_ILLEGAL: err_next = 1'b1;
            default: ;
          endcase
        end
      end
      RD, WR, FIFO_SEND: begin
        // abort outranks done, which outranks the watchdog
        if (abort) begin
          next_state = IDLE;
          words_next = '0;
        end else if (done) begin
          if (state != FIFO_SEND || words_left <= CNT_W'(1)) begin
            next_state = IDLE;
            words_next = '0;
          end else begin
            words_next = words_left - CNT_W'(1);
          end
        end else if (wd_expire) begin
          next_state = IDLE;
          words_next = '0;
          tmo_next   = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        words_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch_q        <= '0;
      words_left  <= '0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
      rd_select   <= 1'b0;
      wr_select   <= 1'b0;
      fifo_select <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      ch_q        <= ch_next;
      words_left  <= words_next;
      cmd_err     <= err_next;
      timeout_err <= tmo_next;
      rd_select   <= (next_state == RD);
      wr_select   <= (next_state == WR);
      fifo_select <= (next_state == FIFO_SEND) ? (N_CH'(1) << ch_next) : '0;
      busy        <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// tb/tb_spi_cmd_seq.sv - directed self-checking bench for spi_cmd_seq
module tb_spi_cmd_seq;

  localparam int CMD_W = 4, CNT_W = 8, N_CH = 4, CH_W = 3, TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic [CH_W-1:0]  ch_sel;
  logic [CNT_W-1:0] pk_sz;
  logic             done;
  logic             abort;
  logic             rd_select, wr_select, busy, cmd_err, timeout_err;
  logic [N_CH-1:0]  fifo_select;
  logic [CNT_W-1:0] words_left;

  int vectors = 0;
  int miscompares = 0;

  spi_cmd_seq #(
    .CMD_W(CMD_W), .CNT_W(CNT_W), .N_CH(N_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .ch_sel      (ch_sel),
    .pk_sz       (pk_sz),
    .done        (done),
    .abort       (abort),
    .rd_select   (rd_select),
    .wr_select   (wr_select),
    .fifo_select (fifo_select),
    .busy        (busy),
    .words_left  (words_left),
    .cmd_err     (cmd_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int c, input int ch, input int pk);
    cmd       = CMD_W'(c);
    ch_sel    = CH_W'(ch);
    pk_sz     = CNT_W'(pk);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd = '0; cmd_valid = 1'b0; ch_sel = '0; pk_sz = '0; done = 1'b0; abort = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_words", 32'(words_left), 0);
    check("rst_fifo", 32'(fifo_select), 0);
    check("rst_tmo", 32'(timeout_err), 0);
    rst = 1'b0;
    tick();

    // FIFO packet of 3 on channel 2
    issue(1, 2, 3);
    check("fifo_sel", 32'(fifo_select), 32'h4);
    check("fifo_busy", 32'(busy), 1);
    check("fifo_w3", 32'(words_left), 3);
    pulse_done();
    check("fifo_w2", 32'(words_left), 2);
    tick();
    check("fifo_hold_w2", 32'(words_left), 2);
    check("fifo_hold_sel", 32'(fifo_select), 32'h4);
    pulse_done();
    check("fifo_w1", 32'(words_left), 1);
    check("fifo_busy_w1", 32'(busy), 1);
    pulse_done();
    check("fifo_w0", 32'(words_left), 0);
    check("fifo_idle", 32'(busy), 0);
    check("fifo_sel_off", 32'(fifo_select), 0);
    pulse_done();
    check("fifo_extra_done", 32'(busy), 0);

    // RD then WR: strobe high for exactly 4 cycles, stray cmd_valid ignored
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 2 : 3, 0, 0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
        if ((k == 0) ? rd_select : wr_select) n++;
        check("sel_other_low", 32'((k == 0) ? wr_select : rd_select), 0);
        if (i == 1) begin
          cmd = CMD_W'(k == 0 ? 3 : 2);
          cmd_valid = 1'b1;
        end
        if (i == 3) done = 1'b1;
        tick();
        cmd_valid = 1'b0;
        done = 1'b0;
      end
      check("sel_cycles", 32'(n), 4);
      check("sel_off", 32'(rd_select | wr_select), 0);
      check("sel_idle", 32'(busy), 0);
    end

    // rejected commands
    issue(7, 0, 1);
    check("err_illegal", 32'(cmd_err), 1);
    check("err_illegal_idle", 32'(busy), 0);
    tick();
    check("err_one_cycle", 32'(cmd_err), 0);
    issue(1, 5, 3);
    check("err_ch", 32'(cmd_err), 1);
    check("err_ch_idle", 32'(busy), 0);
    tick();
    check("err_ch_one_cycle", 32'(cmd_err), 0);
    issue(1, 1, 0);
    check("pk0_no_err", 32'(cmd_err), 0);
    check("pk0_idle", 32'(busy), 0);
    check("pk0_fifo", 32'(fifo_select), 0);

    // watchdog on WR with no done
    issue(3, 0, 0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("wd_cycles", 32'(n), 16);
    check("wd_tmo", 32'(timeout_err), 1);
    check("wd_wr_off", 32'(wr_select), 0);
    issue(2, 0, 0);
    check("wd_clear", 32'(timeout_err), 0);
    check("wd_rd", 32'(rd_select), 1);
    pulse_done();

    // abort together with done in FIFO_SEND
    issue(1, 0, 5);
    check("ab_sel", 32'(fifo_select), 32'h1);
    check("ab_w5", 32'(words_left), 5);
    pulse_done();
    check("ab_w4", 32'(words_left), 4);
    abort = 1'b1; done = 1'b1;
    tick();
    abort = 1'b0; done = 1'b0;
    check("ab_idle", 32'(busy), 0);
    check("ab_w0", 32'(words_left), 0);
    check("ab_sel_off", 32'(fifo_select), 0);
    abort = 1'b1;
    issue(2, 0, 0);
    abort = 1'b0;
    check("ab_idle_cmd", 32'(rd_select), 1);
    pulse_done();

    // asynchronous reset mid-packet
    issue(1, 3, 5);
    check("ar_w5", 32'(words_left), 5);
    check("ar_sel", 32'(fifo_select), 32'h8);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_words", 32'(words_left), 0);
    check("ar_fifo", 32'(fifo_select), 0);
    check("ar_strobes", 32'({rd_select, wr_select, cmd_err, timeout_err}), 0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cmd_seq.md
Name: spi_cmd_seq

Overview:
Parametrised command sequencer for the SPI slave on the Cyclone III digitizer. It decodes a command word from the SPI front end and drives one-hot read/write select strobes to the register path. It also streams a FIFO packet of programmable length from one of N_CH channel FIFOs. Successor to the single-channel SPI state machine: adds channel selection, a command-valid qualifier, abort, a watchdog timeout and error reporting.

Parameters:
CMD_W, 4, command word width
CNT_W, 8, packet word-counter width
N_CH, 4, number of channel FIFOs (>=1)
CH_W, $clog2(N_CH) (min 1), channel index width
TIMEOUT, 1023, max cycles allowed between done pulses in a non-IDLE state; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd  in  CMD_W  command code, sampled only when cmd_valid=1 in IDLE
cmd_valid  in  1  one-cycle command qualifier
ch_sel  in  CH_W  FIFO channel for the FIFO command, sampled with cmd
pk_sz  in  CNT_W  words to send for the FIFO command, sampled with cmd
done  in  1  one-cycle pulse: current SPI transfer complete
abort  in  1  force return to IDLE
rd_select  out  1  high while in RD
wr_select  out  1  high while in WR
fifo_select  out  N_CH  one-hot; bit ch high while in FIFO_SEND for channel ch
busy  out  1  high whenever state != IDLE
words_left  out  CNT_W  FIFO words still to send
cmd_err  out  1  one-cycle pulse on a rejected command
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, including words_left, the latched channel and the watchdog count.
- Command codes: NOP=0, FIFO=1, RD=2, WR=3. Every other code is illegal.
- States: one-hot IDLE, RD, WR, FIFO_SEND.
- IDLE with cmd_valid=1:
  - RD -> RD; WR -> WR.
  - FIFO with ch_sel<N_CH and pk_sz!=0 -> FIFO_SEND. Latch the channel; words_left <= pk_sz.
  - FIFO with pk_sz=0 -> stay IDLE, no error.
  - Illegal code, or FIFO with ch_sel>=N_CH -> stay IDLE; cmd_err=1 for the next cycle.
  - NOP -> stay IDLE.
  - Any accepted (non-NOP) command clears timeout_err.
- cmd_valid outside IDLE is ignored; no error is raised.
- RD / WR: done=1 -> IDLE; otherwise hold.
- FIFO_SEND: each done decrements words_left. When done=1 and words_left=1, go to IDLE with words_left=0. A packet is exactly pk_sz done pulses, never pk_sz+1.
- abort=1 in any non-IDLE state -> IDLE next cycle and words_left <= 0. abort takes priority over done and timeout. abort in IDLE has no effect, and a same-cycle command is still accepted.
- Watchdog:
  - Counter clears on state entry and on every done.
  - It increments each non-IDLE cycle.
  - When the counter reaches TIMEOUT -> IDLE, words_left <= 0, timeout_err <= 1.
  - Disabled when TIMEOUT=0.
- Output timing: all outputs are registered and decoded from nextstate, so select strobes and busy change on the same edge as state, with no extra cycle of latency. Exactly one of rd_select, wr_select or one fifo_select bit is high at a time.
- Counter arithmetic is CNT_W bits and never wraps below 0.

Decomposition:
- Package spi_cmd_pkg holds the command code constants, the state-index constants and the command-decode function.
- Sub-module spi_wdog: watchdog counter with inputs clr, en, and output expire at TIMEOUT. It is a natural split and is reused by the later SPI master.

Test Plan:
- Reset mid-FIFO_SEND (words_left=5): assert rst asynchronously -> all outputs 0 before the next clk edge; state IDLE.
- cmd=FIFO, ch_sel=2, pk_sz=3, then 3 done pulses -> fifo_select=4'b0100 and busy=1 for the packet; words_left 3,2,1,0; IDLE after the 3rd done, not the 4th.
- cmd=RD, done 4 cycles later -> rd_select high for exactly 4 cycles. Same check for cmd=WR with wr_select.
- cmd=7 and cmd=FIFO with ch_sel=5 (N_CH=4, CH_W=3) -> single-cycle cmd_err each; state stays IDLE. cmd=FIFO with pk_sz=0 -> no error and no transition.
- TIMEOUT=16, cmd=WR with no done -> IDLE after 16 cycles and timeout_err=1. The next cmd=RD clears it.
- FIFO_SEND with abort and done in the same cycle -> IDLE and words_left=0 next cycle; cmd_valid asserted during RD is ignored.
